multi_alarm_unit: RTL and testbench
===================================

Name: multi_alarm_unit

Overview:
- Parametrised successor to the single-alarm path: holds NUM_ALARMS independent BCD alarm times, each with its own enable.
- Detects when the current time first matches any enabled alarm, then drives a ring / snooze / auto-silence state machine.
- Sits between the minute counter (current time, one_minute tick) and the display/sound path; replaces the single alarm register plus its compare.

Parameters:
- NUM_ALARMS, 4: number of alarm slots.
- IDX_W, 2: slot index width; must satisfy 2^IDX_W >= NUM_ALARMS.
- SNOOZE_MIN, 5: number of one_minute pulses spent in snooze before re-ringing (>=1).
- RING_TIMEOUT_MIN, 10: number of one_minute pulses of ringing before auto-silence (>=1).
- MAX_SNOOZE, 3: snoozes allowed per trigger (0..15).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- one_minute  in  1  single-cycle minute tick from the timing generator
- current_time  in  16  BCD {ms_hr, ls_hr, ms_min, ls_min}
- load_alarm  in  1  write strobe
- alarm_index  in  IDX_W  write address and read address
- new_alarm_time  in  16  BCD alarm time to write
- alarm_enable  in  NUM_ALARMS  per-slot enable, level
- stop_button  in  1  single-cycle pulse, debounced upstream
- snooze_button  in  1  single-cycle pulse, debounced upstream
- alarm_time_rd  out  16  combinational read of slot[alarm_index]; 0 if the index is out of range
- alarm_sound  out  1  registered; high while RINGING
- snoozed  out  1  registered; high while SNOOZED
- ringing_index  out  IDX_W  slot that caused the current ring or snooze
- snooze_count  out  4  snoozes taken for the current trigger

Behaviour:
- Reset (reset=0, async):
  - All slots = 16'h0000; match_q = 0.
  - State = IDLE; ring_cnt, snz_cnt, snooze_count, ringing_index = 0.
  - alarm_sound = snoozed = 0.
- Slot write:
  - When load_alarm=1, slot[alarm_index] <= new_alarm_time on the clock edge.
  - alarm_index >= NUM_ALARMS: write is ignored.
  - Contents are not BCD-checked.
- Match and trigger:
  - match[i] = alarm_enable[i] && (slot[i] == current_time).
  - match_q <= match every cycle.
  - trig = |(match & ~match_q): rising-edge detect, so a held match fires exactly once.
  - Winner = lowest index among the rising bits.
- Latency: alarm_sound rises on the first clock edge where trig=1, i.e. visible one cycle after the match appears. A slot written equal to current_time while enabled triggers the same way.
- Priority inside any state: stop_button > disable of ringing slot > trig > snooze_button > one_minute.
- FSM:
  - IDLE:
    - trig -> RINGING; ringing_index = winner; ring_cnt = 0; snooze_count = 0.
  - RINGING (alarm_sound=1):
    - stop -> IDLE.
    - alarm_enable[ringing_index]=0 -> IDLE.
    - trig from another slot -> stay RINGING; ringing_index = winner; ring_cnt = 0; snooze_count = 0.
    - snooze with snooze_count < MAX_SNOOZE -> SNOOZED; snz_cnt = 0; snooze_count++.
    - snooze with snooze_count = MAX_SNOOZE -> ignored.
    - one_minute -> ring_cnt++; the pulse that makes ring_cnt reach RING_TIMEOUT_MIN -> IDLE (auto-silence).
  - SNOOZED (snoozed=1, alarm_sound=0):
    - stop -> IDLE.
    - disable of ringing slot -> IDLE.
    - trig -> RINGING with the new winner; snooze_count = 0; ring_cnt = 0.
    - one_minute -> snz_cnt++; the pulse that makes snz_cnt reach SNOOZE_MIN -> RINGING; ring_cnt = 0.
    - snooze_button -> ignored.
- Counter widths: ring_cnt and snz_cnt must be wide enough for their maximum parameter value. Counters never wrap inside a state; they are cleared on entry.
- On return to IDLE: ringing_index and snooze_count hold their last values for readout.
- Reset asserted mid-ring or mid-snooze: immediate IDLE, outputs low, alarm times lost.

Test Plan:
- Slot write/readback: write slot2=16'h0730, alarm_index=2 -> alarm_time_rd=16'h0730. Write with alarm_index=5 under NUM_ALARMS=4 -> no slot changes; read of index 5 returns 0.
- Basic trigger: slot1=0645 enabled, current_time steps 0644->0645 -> alarm_sound=1 one cycle after the step; ringing_index=1. Holding 0645 for 60 one_minute-free cycles after stop -> no re-trigger.
- Snooze limit: ring, then snooze three times, each lasting 5 one_minute pulses -> snooze_count=1,2,3 with re-ring after each snooze. A fourth snooze_button -> stays RINGING.
- Auto-silence: ring with no buttons, 10 one_minute pulses -> alarm_sound drops on the 10th pulse edge; state IDLE.
- Simultaneous events: slots 0 and 3 both = 0900, both enabled -> ringing_index=0. stop_button and snooze_button in the same cycle -> IDLE. Clearing alarm_enable[0] while SNOOZED -> snoozed=0 next cycle.
- Async reset mid-ring: pull reset low between clock edges -> alarm_sound=0 immediately; all slots read 0000 after release.

Source files
------------

// File: rtl/multi_alarm_unit.sv
// multi_alarm_unit
//   Holds NUM_ALARMS BCD alarm times, each with its own enable. When the
//   current time first matches an enabled alarm, it rings. The user can snooze
//   it a limited number of times, stop it, or let it silence itself.
//
// Ports
//   clock           system clock
//   reset           asynchronous active-low reset
//   one_minute      single-cycle minute tick
//   current_time    BCD {ms_hr, ls_hr, ms_min, ls_min}
//   load_alarm      write strobe for slot[alarm_index]
//   alarm_index     write address and read address
//   new_alarm_time  BCD alarm time to write
//   alarm_enable    per-slot enable (level)
//   stop_button     single-cycle pulse
//   snooze_button   single-cycle pulse
//   alarm_time_rd   combinational read of slot[alarm_index]; 0 if out of range
//   alarm_sound     high while ringing
//   snoozed         high while snoozed
//   ringing_index   slot that caused the current or last ring
//   snooze_count    snoozes taken for the current or last trigger
module multi_alarm_unit #(
  parameter int NUM_ALARMS       = 4,
  parameter int IDX_W            = 2,
  parameter int SNOOZE_MIN       = 5,
  parameter int RING_TIMEOUT_MIN = 10,
  parameter int MAX_SNOOZE       = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  one_minute,
  input  logic [15:0]           current_time,
  input  logic                  load_alarm,
  input  logic [IDX_W-1:0]      alarm_index,
  input  logic [15:0]           new_alarm_time,
  input  logic [NUM_ALARMS-1:0] alarm_enable,
  input  logic                  stop_button,
  input  logic                  snooze_button,
  output logic [15:0]           alarm_time_rd,
  output logic                  alarm_sound,
  output logic                  snoozed,
  output logic [IDX_W-1:0]      ringing_index,
  output logic [3:0]            snooze_count
);

  localparam int RING_W = $clog2(RING_TIMEOUT_MIN + 1);
  localparam int SNZ_W  = $clog2(SNOOZE_MIN + 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RINGING = 2'd1,
    ST_SNOOZED = 2'd2
  } state_t;

  logic [15:0]           slot_q [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] match;
  logic [NUM_ALARMS-1:0] match_q;
  logic [NUM_ALARMS-1:0] rise;
  logic                  trig;
  logic [IDX_W-1:0]      winner;
  logic                  ring_en;

  state_t           state_q, state_d;
  logic [RING_W-1:0] ring_cnt_q, ring_cnt_d;
  logic [SNZ_W-1:0]  snz_cnt_q, snz_cnt_d;
  logic [IDX_W-1:0]  ring_idx_q, ring_idx_d;
  logic [3:0]        snooze_cnt_q, snooze_cnt_d;

  // Slot storage. Indices at or above NUM_ALARMS match no slot, so such
  // writes fall on the floor.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_ALARMS; i++) slot_q[i] <= '0;
    end else if (load_alarm) begin
      for (int i = 0; i < NUM_ALARMS; i++)
        if (alarm_index == IDX_W'(i)) slot_q[i] <= new_alarm_time;
    end
  end

  always_comb begin
    alarm_time_rd = '0;
    for (int i = 0; i < NUM_ALARMS; i++)
      if (alarm_index == IDX_W'(i)) alarm_time_rd = slot_q[i];
  end

  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_ALARMS; i++)
      match[i] = alarm_enable[i] && (slot_q[i] == current_time);
  end

  // Rising-edge detect so a held match fires once.
  assign rise = match & ~match_q;
  assign trig = |rise;

  // Descending scan: the lowest rising index is written last and wins.
  always_comb begin
    winner = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--)
      if (rise[i]) winner = IDX_W'(i);
  end

  always_comb begin
    ring_en = 1'b0;
    for (int i = 0; i < NUM_ALARMS; i++)
      if (ring_idx_q == IDX_W'(i)) ring_en = alarm_enable[i];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) match_q <= '0;
    else        match_q <= match;
  end

  // Priority: stop > disable of ringing slot > trig > snooze > one_minute.
  // A trig while active re-arms on the new winner, even if it is the same slot
  // rising again. A snooze beyond the limit is ignored and lets a coincident
  // minute tick count.
  always_comb begin
    state_d      = state_q;
    ring_cnt_d   = ring_cnt_q;
    snz_cnt_d    = snz_cnt_q;
    ring_idx_d   = ring_idx_q;
    snooze_cnt_d = snooze_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (!stop_button && trig) begin
          state_d      = ST_RINGING;
          ring_idx_d   = winner;
          ring_cnt_d   = '0;
          snooze_cnt_d = '0;
        end
      end
      ST_RINGING: begin
        if (stop_button || !ring_en) begin
          state_d = ST_IDLE;
        end else if (trig) begin
          ring_idx_d   = winner;
          ring_cnt_d   = '0;
          snooze_cnt_d = '0;
        end else if (snooze_button && (snooze_cnt_q < 4'(MAX_SNOOZE))) begin
          state_d      = ST_SNOOZED;
          snz_cnt_d    = '0;
          snooze_cnt_d = snooze_cnt_q + 4'd1;
        end else if (one_minute) begin
          ring_cnt_d = ring_cnt_q + RING_W'(1);
          if (ring_cnt_d == RING_W'(RING_TIMEOUT_MIN)) state_d = ST_IDLE;
        end
      end
      ST_SNOOZED: begin
        if (stop_button || !ring_en) begin
          state_d = ST_IDLE;
        end else if (trig) begin
          state_d      = ST_RINGING;
          ring_idx_d   = winner;
          ring_cnt_d   = '0;
          snooze_cnt_d = '0;
        end else if (one_minute) begin
          snz_cnt_d = snz_cnt_q + SNZ_W'(1);
          if (snz_cnt_d == SNZ_W'(SNOOZE_MIN)) begin
            state_d    = ST_RINGING;
            ring_cnt_d = '0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      ring_cnt_q   <= '0;
      snz_cnt_q    <= '0;
      ring_idx_q   <= '0;
      snooze_cnt_q <= '0;
      alarm_sound  <= 1'b0;
      snoozed      <= 1'b0;
    end else begin
      state_q      <= state_d;
      ring_cnt_q   <= ring_cnt_d;
      snz_cnt_q    <= snz_cnt_d;
      ring_idx_q   <= ring_idx_d;
      snooze_cnt_q <= snooze_cnt_d;
      alarm_sound  <= (state_d == ST_RINGING);
      snoozed      <= (state_d == ST_SNOOZED);
    end
  end

  assign ringing_index = ring_idx_q;
  assign snooze_count  = snooze_cnt_q;

endmodule

// File: tb/tb_multi_alarm_unit.sv
// Bench for multi_alarm_unit: directed scenarios followed by random traffic,
// all checked against a behavioural model of the alarm rules.
module tb_multi_alarm_unit;

  localparam int NA    = 4;
  localparam int IW    = 3;
  localparam int SNZ   = 5;
  localparam int RTO   = 10;
  localparam int MAXS  = 3;

  localparam int M_OFF   = 0;
  localparam int M_RING  = 1;
  localparam int M_SLEEP = 2;

  logic          clock;
  logic          reset;
  logic          one_minute;
  logic [15:0]   current_time;
  logic          load_alarm;
  logic [IW-1:0] alarm_index;
  logic [15:0]   new_alarm_time;
  logic [NA-1:0] alarm_enable;
  logic          stop_button;
  logic          snooze_button;
  logic [15:0]   alarm_time_rd;
  logic          alarm_sound;
  logic          snoozed;
  logic [IW-1:0] ringing_index;
  logic [3:0]    snooze_count;

  int n_checks = 0;
  int n_pass   = 0;

  multi_alarm_unit #(
    .NUM_ALARMS(NA), .IDX_W(IW), .SNOOZE_MIN(SNZ),
    .RING_TIMEOUT_MIN(RTO), .MAX_SNOOZE(MAXS)
  ) dut (
    .clock(clock), .reset(reset), .one_minute(one_minute),
    .current_time(current_time), .load_alarm(load_alarm),
    .alarm_index(alarm_index), .new_alarm_time(new_alarm_time),
    .alarm_enable(alarm_enable), .stop_button(stop_button),
    .snooze_button(snooze_button), .alarm_time_rd(alarm_time_rd),
    .alarm_sound(alarm_sound), .snoozed(snoozed),
    .ringing_index(ringing_index), .snooze_count(snooze_count)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "timeout");
  end

  // behavioural model
  int m_slot [NA];
  bit [NA-1:0] m_prev;
  int m_mode, m_idx, m_taken, m_ring_min, m_sleep_min;

  function automatic void model_reset();
    for (int i = 0; i < NA; i++) m_slot[i] = 0;
    m_prev = '0; m_mode = M_OFF; m_idx = 0; m_taken = 0;
    m_ring_min = 0; m_sleep_min = 0;
  endfunction

  function automatic int model_rd(input int idx);
    return (idx < NA) ? m_slot[idx] : 0;
  endfunction

  function automatic void model_step();
    bit [NA-1:0] now_match;
    int first;
    bit fresh;
    now_match = '0;
    for (int i = 0; i < NA; i++)
      now_match[i] = alarm_enable[i] && (m_slot[i] == int'(current_time));
    first = -1;
    for (int i = 0; i < NA; i++)
      if (now_match[i] && !m_prev[i] && first < 0) first = i;
    fresh = (first >= 0);
    m_prev = now_match;

    if (m_mode == M_OFF) begin
      if (!stop_button && fresh) begin
        m_mode = M_RING; m_idx = first; m_ring_min = 0; m_taken = 0;
      end
    end else if (stop_button || !alarm_enable[m_idx]) begin
      m_mode = M_OFF;
    end else if (fresh) begin
      m_mode = M_RING; m_idx = first; m_ring_min = 0; m_taken = 0;
    end else if (m_mode == M_RING) begin
      if (snooze_button && m_taken < MAXS) begin
        m_mode = M_SLEEP; m_sleep_min = 0; m_taken++;
      end else if (one_minute) begin
        m_ring_min++;
        if (m_ring_min == RTO) m_mode = M_OFF;
      end
    end else begin
      if (one_minute) begin
        m_sleep_min++;
        if (m_sleep_min == SNZ) begin m_mode = M_RING; m_ring_min = 0; end
      end
    end

    if (load_alarm && alarm_index < NA) m_slot[alarm_index] = int'(new_alarm_time);
  endfunction

  // scoreboard
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic compare_all();
    check("sound", 32'(alarm_sound), 32'(m_mode == M_RING));
    check("snoozed", 32'(snoozed), 32'(m_mode == M_SLEEP));
    check("ring_idx", 32'(ringing_index), 32'(m_idx));
    check("snz_cnt", 32'(snooze_count), 32'(m_taken));
    check("rd", 32'(alarm_time_rd), 32'(model_rd(int'(alarm_index))));
  endtask

  // driver
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clock);
      model_step();
      #1;
      compare_all();
      stop_button = 1'b0; snooze_button = 1'b0;
      one_minute = 1'b0; load_alarm = 1'b0;
    end
  endtask

  task automatic write_slot(input int idx, input logic [15:0] t);
    load_alarm = 1'b1; alarm_index = IW'(idx); new_alarm_time = t;
    tick(1);
  endtask

  task automatic minutes(input int n);
    for (int k = 0; k < n; k++) begin
      one_minute = 1'b1;
      tick(1);
    end
  endtask

  logic [15:0] times [4];

  initial begin
    times[0] = 16'h0000; times[1] = 16'h0645;
    times[2] = 16'h0900; times[3] = 16'h1230;
    reset = 1'b0; one_minute = 0; current_time = '0; load_alarm = 0;
    alarm_index = '0; new_alarm_time = '0; alarm_enable = '0;
    stop_button = 0; snooze_button = 0;
    model_reset();
    #12;
    check("rst_sound", 32'(alarm_sound), 0);
    check("rst_snoozed", 32'(snoozed), 0);
    check("rst_idx", 32'(ringing_index), 0);
    check("rst_count", 32'(snooze_count), 0);
    @(negedge clock);
    reset = 1'b1;

    // slot write / readback, including an out-of-range index
    write_slot(2, 16'h0730);
    check("rd_slot2", 32'(alarm_time_rd), 32'h0730);
    write_slot(5, 16'h1234);
    check("rd_oor", 32'(alarm_time_rd), 0);
    for (int i = 0; i < NA; i++) begin
      alarm_index = IW'(i);
      #1;
      check("rd_after_oor", 32'(alarm_time_rd), (i == 2) ? 32'h0730 : 0);
    end

    // basic trigger and no re-trigger on a held match
    current_time = 16'h0644; alarm_enable = 4'b0010;
    write_slot(1, 16'h0645);
    tick(1);
    current_time = 16'h0645;
    tick(1);
    check("basic_sound", 32'(alarm_sound), 1);
    check("basic_idx", 32'(ringing_index), 1);
    stop_button = 1'b1;
    tick(1);
    check("stop_sound", 32'(alarm_sound), 0);
    tick(60);
    check("no_retrig", 32'(alarm_sound), 0);

    // snooze limit
    current_time = 16'h0100; tick(1);
    current_time = 16'h0645; tick(1);
    check("snz_ring", 32'(alarm_sound), 1);
    for (int k = 1; k <= MAXS; k++) begin
      snooze_button = 1'b1; tick(1);
      check("snz_state", 32'(snoozed), 1);
      check("snz_num", 32'(snooze_count), 32'(k));
      minutes(SNZ);
      check("rering", 32'(alarm_sound), 1);
    end
    snooze_button = 1'b1; tick(1);
    check("snz_limit", 32'(alarm_sound), 1);
    check("snz_limit_cnt", 32'(snooze_count), 32'(MAXS));

    // auto-silence
    minutes(RTO - 1);
    check("pre_silence", 32'(alarm_sound), 1);
    minutes(1);
    check("silence", 32'(alarm_sound), 0);

    // simultaneous events
    write_slot(0, 16'h0900);
    write_slot(3, 16'h0900);
    alarm_enable = 4'b1001;
    current_time = 16'h0800; tick(1);
    current_time = 16'h0900; tick(1);
    check("lowest_idx", 32'(ringing_index), 0);
    stop_button = 1'b1; snooze_button = 1'b1; tick(1);
    check("stop_wins", 32'(alarm_sound | snoozed), 0);
    current_time = 16'h0800; tick(1);
    current_time = 16'h0900; tick(1);
    snooze_button = 1'b1; tick(1);
    check("snz_slot0", 32'(snoozed), 1);
    alarm_enable = 4'b1000; tick(1);
    check("disable_snz", 32'(snoozed), 0);

    // asynchronous reset mid-ring
    alarm_enable = 4'b1001;
    current_time = 16'h0800; tick(1);
    current_time = 16'h0900; tick(1);
    check("pre_reset_ring", 32'(alarm_sound), 1);
    #2 reset = 1'b0;
    #1;
    check("async_sound", 32'(alarm_sound), 0);
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < NA; i++) begin
      alarm_index = IW'(i);
      #1;
      check("rd_after_rst", 32'(alarm_time_rd), 0);
    end
    tick(1);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 9) == 0) begin
        load_alarm = 1'b1;
        alarm_index = IW'($urandom_range(0, 7));
        new_alarm_time = times[$urandom_range(0, 3)];
      end else begin
        alarm_index = IW'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 7) == 0) alarm_enable = NA'($urandom_range(0, 15));
      if ($urandom_range(0, 5) == 0) current_time = times[$urandom_range(0, 3)];
      one_minute    = ($urandom_range(0, 2) == 0);
      stop_button   = ($urandom_range(0, 39) == 0);
      snooze_button = ($urandom_range(0, 9) == 0);
      tick(1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
